multicycle_ctrl: RTL and testbench

//  Main control FSM of the RV32I multicycle core. Sequences FETCH/DECODE/EXEC/MEM/WB per instruction.

---
 rtl/multicycle_ctrl_pkg.sv | 52 +++++
 rtl/multicycle_ctrl_decode.sv | 24 ++
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control path: states, opcodes, instruction
// classes and the ALU/writeback/PC select codes that the datapath muxes decode.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU     = 4'd0,
    CLS_LOAD    = 4'd1,
    CLS_STORE   = 4'd2,
    CLS_BRANCH  = 4'd3,
    CLS_JAL     = 4'd4,
    CLS_JALR    = 4'd5,
    CLS_LUI     = 4'd6,
    CLS_AUIPC   = 4'd7,
    CLS_ILLEGAL = 4'd8
  } class_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_SLT  = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_FUNC = 3'd4;
  localparam logic [2:0] ALU_BR   = 3'd5;

  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_LOAD = 3'd1;
  localparam logic [2:0] WB_PC4  = 3'd2;
  localparam logic [2:0] WB_IMM  = 3'd3;

  localparam logic [2:0] PC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_TARGET = 3'd1;
  localparam logic [2:0] PC_JALR   = 3'd2;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode classifier; anything not in the RV32I base opcode map is illegal.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_OP, OPC_OP_IMM: cls = CLS_ALU;
      OPC_LOAD:           cls = CLS_LOAD;
      OPC_STORE:          cls = CLS_STORE;
      OPC_BRANCH:         cls = CLS_BRANCH;
      OPC_JAL:            cls = CLS_JAL;
      OPC_JALR:           cls = CLS_JALR;
      OPC_LUI:            cls = CLS_LUI;
      OPC_AUIPC:          cls = CLS_AUIPC;
      default:            cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main FETCH/DECODE/EXEC/MEM/WB sequencer of the RV32I multicycle core.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of retiring them as NOPs.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_re,
  output logic        mem_we,
  output logic        iord_sel,
  output logic        ir_we,
  output logic        ab_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic [2:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  alu_ctl,
  output logic [2:0]  wb_sel,
  output logic        illegal
);

  state_t     state_reg, state_next;
  logic [6:0] opcode_reg;
  logic [3:0] cls_bits;
  class_t     cls;

  logic mem_re_c, mem_we_c, ir_we_c, ab_we_c, reg_we_c, pc_we_c;

  // Only the opcode field is held; the datapath keeps the full IR.
  logic unused_instr;
  assign unused_instr = ^instr[31:7];

  multicycle_ctrl_decode u_decode (
    .opcode (opcode_reg),
    .cls    (cls_bits)
  );
  assign cls = class_t'(cls_bits);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= state_t'(RESET_STATE);
      opcode_reg <= 7'd0;
    end else begin
      state_reg <= state_next;
      if (ir_we_c) opcode_reg <= instr[6:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_re_c   = 1'b0;
    mem_we_c   = 1'b0;
    ir_we_c    = 1'b0;
    ab_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    pc_we_c    = 1'b0;
    iord_sel   = 1'b0;
    pc_sel     = PC_PLUS4;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    alu_ctl    = ALU_ADD;
    wb_sel     = WB_ALU;
    case (state_reg)
      ST_FETCH: begin
        mem_re_c = 1'b1;
        if (mem_ready) begin
          ir_we_c    = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ab_we_c    = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls)
          CLS_ALU: begin
            alu_ctl    = ALU_FUNC;
            alu_b_sel  = (opcode_reg == OPC_OP_IMM);
            state_next = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_b_sel  = 1'b1;
            state_next = ST_MEM;
          end
          CLS_LUI, CLS_JAL, CLS_JALR: state_next = ST_WB;
          CLS_AUIPC: begin
            alu_a_sel  = 1'b1;
            alu_b_sel  = 1'b1;
            state_next = ST_WB;
          end
          CLS_BRANCH: begin
            alu_ctl    = ALU_BR;
            pc_we_c    = 1'b1;
            pc_sel     = br_taken ? PC_TARGET : PC_PLUS4;
            state_next = ST_FETCH;
          end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_next = ST_TRAP;
`else
            pc_we_c    = 1'b1;
            state_next = ST_FETCH;
`endif
          end
        endcase
      end
      ST_MEM: begin
        iord_sel = 1'b1;
        if (cls == CLS_LOAD) mem_re_c = 1'b1;
        else                 mem_we_c = 1'b1;
        if (mem_ready) begin
          if (cls == CLS_LOAD) begin
            state_next = ST_WB;
          end else begin
            pc_we_c    = 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        reg_we_c   = 1'b1;
        pc_we_c    = 1'b1;
        state_next = ST_FETCH;
        case (cls)
          CLS_LOAD: wb_sel = WB_LOAD;
          CLS_LUI:  wb_sel = WB_IMM;
          CLS_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_TARGET;
          end
          CLS_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_JALR;
          end
          default:  wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP:  state_next = ST_TRAP;
      default:  state_next = ST_FETCH;
    endcase
  end

  // Strobes are masked by rst so an aborted instruction issues nothing more.
  assign mem_re = mem_re_c & ~rst;
  assign mem_we = mem_we_c & ~rst;
  assign ir_we  = ir_we_c  & ~rst;
  assign ab_we  = ab_we_c  & ~rst;
  assign reg_we = reg_we_c & ~rst;
  assign pc_we  = pc_we_c  & ~rst;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        illegal_reg <= 1'b0;
    else if (state_reg == ST_EXEC && cls == CLS_ILLEGAL) illegal_reg <= 1'b1;
  end
  assign illegal = illegal_reg;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; trap-mode checks follow CTRL_ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        br_taken;
  logic        mem_re, mem_we, iord_sel, ir_we, ab_we, reg_we, pc_we;
  logic [2:0]  pc_sel, alu_ctl, wb_sel;
  logic        alu_a_sel, alu_b_sel, illegal;

  int compared = 0;
  int mismatched = 0;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .mem_ready (mem_ready),
    .br_taken  (br_taken),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .iord_sel  (iord_sel),
    .ir_we     (ir_we),
    .ab_we     (ab_we),
    .reg_we    (reg_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_ctl   (alu_ctl),
    .wb_sel    (wb_sel),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before driving or sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in FETCH with mem_ready=1 and advance into DECODE.
  task automatic fetch(input string tag, input logic [31:0] word);
    instr = word;
    mem_ready = 1'b1;
    #1;
    chk({tag, "_fetch_mem_re"}, 32'(mem_re), 32'd1);
    chk({tag, "_fetch_ir_we"}, 32'(ir_we), 32'd1);
    step();
    mem_ready = 1'b0;
    #1;
    chk({tag, "_decode_ab_we"}, 32'(ab_we), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    instr = 32'd0;
    mem_ready = 1'b0;
    br_taken = 1'b0;
    #2;
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_pc_we", 32'(pc_we), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("fetch_mem_re", 32'(mem_re), 32'd1);
    chk("fetch_iord", 32'(iord_sel), 32'd0);
    chk("fetch_hold_ir_we", 32'(ir_we), 32'd0);
    step();
    chk("fetch_hold_mem_re", 32'(mem_re), 32'd1);

    // ADDI x1,x0,5
    fetch("addi", 32'h00500093);
    step();
    chk("addi_exec_alu_ctl", 32'(alu_ctl), 32'd4);
    chk("addi_exec_b_sel", 32'(alu_b_sel), 32'd1);
    chk("addi_exec_pc_we", 32'(pc_we), 32'd0);
    step();
    chk("addi_wb_reg_we", 32'(reg_we), 32'd1);
    chk("addi_wb_pc_we", 32'(pc_we), 32'd1);
    chk("addi_wb_sel", 32'(wb_sel), 32'd0);
    chk("addi_wb_pc_sel", 32'(pc_sel), 32'd0);
    step();
    chk("addi_back_fetch", 32'(mem_re), 32'd1);

    // LW with three wait cycles in MEM
    fetch("lw", 32'h00002083);
    step();
    chk("lw_exec_b_sel", 32'(alu_b_sel), 32'd1);
    chk("lw_exec_alu_ctl", 32'(alu_ctl), 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_mem_re", 32'(mem_re), 32'd1);
      chk("lw_wait_iord", 32'(iord_sel), 32'd1);
      chk("lw_wait_pc_we", 32'(pc_we), 32'd0);
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_last_mem_re", 32'(mem_re), 32'd1);
    chk("lw_last_iord", 32'(iord_sel), 32'd1);
    step();
    mem_ready = 1'b0;
    chk("lw_wb_reg_we", 32'(reg_we), 32'd1);
    chk("lw_wb_sel", 32'(wb_sel), 32'd1);
    chk("lw_wb_pc_sel", 32'(pc_sel), 32'd0);
    step();

    // BEQ, taken then not taken within the EXEC cycle
    fetch("beq", 32'h00000063);
    step();
    br_taken = 1'b1;
    #1;
    chk("beq_t_pc_we", 32'(pc_we), 32'd1);
    chk("beq_t_pc_sel", 32'(pc_sel), 32'd1);
    chk("beq_alu_ctl", 32'(alu_ctl), 32'd5);
    chk("beq_reg_we", 32'(reg_we), 32'd0);
    br_taken = 1'b0;
    #1;
    chk("beq_nt_pc_sel", 32'(pc_sel), 32'd0);
    chk("beq_nt_pc_we", 32'(pc_we), 32'd1);
    step();
    chk("beq_next_fetch", 32'(mem_re), 32'd1);
    chk("beq_next_reg_we", 32'(reg_we), 32'd0);

    // JALR x1,0(x1)
    fetch("jalr", 32'h000080E7);
    step();
    chk("jalr_exec_pc_we", 32'(pc_we), 32'd0);
    step();
    chk("jalr_wb_sel", 32'(wb_sel), 32'd2);
    chk("jalr_pc_sel", 32'(pc_sel), 32'd2);
    chk("jalr_reg_we", 32'(reg_we), 32'd1);
    step();

    // JAL, LUI, AUIPC
    fetch("jal", 32'h0000006F);
    step();
    step();
    chk("jal_wb_sel", 32'(wb_sel), 32'd2);
    chk("jal_pc_sel", 32'(pc_sel), 32'd1);
    step();
    fetch("lui", 32'h000000B7);
    step();
    step();
    chk("lui_wb_sel", 32'(wb_sel), 32'd3);
    step();
    fetch("auipc", 32'h00000097);
    step();
    chk("auipc_a_sel", 32'(alu_a_sel), 32'd1);
    chk("auipc_b_sel", 32'(alu_b_sel), 32'd1);
    step();
    chk("auipc_wb_sel", 32'(wb_sel), 32'd0);
    step();

    // SW, immediate memory completion
    fetch("sw", 32'h00102023);
    step();
    step();
    mem_ready = 1'b1;
    #1;
    chk("sw_mem_we", 32'(mem_we), 32'd1);
    chk("sw_mem_re", 32'(mem_re), 32'd0);
    chk("sw_iord", 32'(iord_sel), 32'd1);
    chk("sw_pc_we", 32'(pc_we), 32'd1);
    chk("sw_pc_sel", 32'(pc_sel), 32'd0);
    chk("sw_reg_we", 32'(reg_we), 32'd0);
    step();
    mem_ready = 1'b0;
    chk("sw_back_fetch", 32'(mem_re), 32'd1);

    // Unknown opcode 0x7F
    fetch("ill", 32'h0000007F);
    step();
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_exec_pc_we", 32'(pc_we), 32'd0);
    step();
    mem_ready = 1'b1;
    #1;
    chk("trap_illegal", 32'(illegal), 32'd1);
    chk("trap_mem_re", 32'(mem_re), 32'd0);
    step();
    step();
    chk("trap_stays", 32'(mem_re), 32'd0);
    chk("trap_stays_illegal", 32'(illegal), 32'd1);
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("trap_rst_illegal", 32'(illegal), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("trap_rst_fetch", 32'(mem_re), 32'd1);
`else
    chk("ill_exec_pc_we", 32'(pc_we), 32'd1);
    chk("ill_exec_pc_sel", 32'(pc_sel), 32'd0);
    chk("ill_exec_reg_we", 32'(reg_we), 32'd0);
    step();
    chk("ill_back_fetch", 32'(mem_re), 32'd1);
    chk("ill_no_flag", 32'(illegal), 32'd0);
`endif

    // SW aborted by rst during its memory wait
    fetch("swrst", 32'h00102023);
    step();
    step();
    chk("swrst_wait_mem_we", 32'(mem_we), 32'd1);
    step();
    chk("swrst_wait2_mem_we", 32'(mem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("swrst_mem_we_drop", 32'(mem_we), 32'd0);
    chk("swrst_pc_we", 32'(pc_we), 32'd0);
    chk("swrst_mem_re", 32'(mem_re), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("swrst_fetch_mem_re", 32'(mem_re), 32'd1);
    chk("swrst_fetch_iord", 32'(iord_sel), 32'd0);
    chk("swrst_fetch_mem_we", 32'(mem_we), 32'd0);
    chk("swrst_fetch_pc_we", 32'(pc_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
